// File: rtl/out_pulse_monitor.sv
// Measures the high time of each pulse on sig_in and rejects pulses shorter than MIN_WIDTH.
// Qualified pulses are queued as {sat, width} records in a first-word-fall-through FIFO.
module out_pulse_monitor #(
  parameter int unsigned WIDTH_W   = 8,
  parameter int unsigned MIN_WIDTH = 1,
  parameter int unsigned DEPTH     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sig_in,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [WIDTH_W-1:0] rec_width,
  output logic               rec_sat,
  output logic [15:0]        evt_count,
  output logic               overflow,
  output logic               busy
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam logic [WIDTH_W-1:0] MAX_CNT = '1;
  localparam logic [WIDTH_W-1:0] ONE_CNT = WIDTH_W'(1);
  localparam logic [WIDTH_W-1:0] MIN_CNT = WIDTH_W'(MIN_WIDTH);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  typedef struct packed {
    logic               sat;
    logic [WIDTH_W-1:0] width;
  } rec_t;

  state_t             state_q, state_d;
  logic               sig_d_q, sig_d_d;
  logic [WIDTH_W-1:0] width_cnt_q, width_cnt_d;
  logic               sat_q, sat_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]        evt_count_q, evt_count_d;
  logic               overflow_q, overflow_d;
  rec_t               last_q, last_d;
  rec_t               mem_q [DEPTH];

  logic rise;
  logic push;
  logic pop;
  logic wr_en;
  logic empty;
  logic full;
  rec_t head;

  assign rise = sig_in & ~sig_d_q;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    width_cnt_d = width_cnt_q;
    sat_d       = sat_q;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d     = MEASURE;
          width_cnt_d = ONE_CNT;
          sat_d       = 1'b0;
        end
      end
      MEASURE: begin
        if (sig_in) begin
          if (width_cnt_q == MAX_CNT) begin
            sat_d = 1'b1;
          end else begin
            width_cnt_d = width_cnt_q + ONE_CNT;
          end
        end else begin
          state_d = IDLE;
          push    = (width_cnt_q >= MIN_CNT);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    empty       = (wr_ptr_q == rd_ptr_q);
    full        = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    head        = mem_q[rd_ptr_q[ADDR_W-1:0]];
    pop         = ~empty & rec_ready;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO is still accepted.
    wr_en       = push & (~full | pop);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    evt_count_d = evt_count_q;
    overflow_d  = overflow_q | (push & ~wr_en);
    last_d      = last_q;
    sig_d_d     = sig_in;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = head;
    end
    if (push) evt_count_d = evt_count_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sig_d_q     <= 1'b1;
      width_cnt_q <= '0;
      sat_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      evt_count_q <= '0;
      overflow_q  <= 1'b0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      sig_d_q     <= sig_d_d;
      width_cnt_q <= width_cnt_d;
      sat_q       <= sat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      evt_count_q <= evt_count_d;
      overflow_q  <= overflow_d;
      last_q      <= last_d;
    end
  end

  // NOTE: record storage is not reset; entries are only read once written, and last_q covers the empty case.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= '{sat: sat_q, width: width_cnt_q};
  end

  assign rec_valid = ~empty;
  assign rec_width = empty ? last_q.width : head.width;
  assign rec_sat   = empty ? last_q.sat   : head.sat;
  assign evt_count = evt_count_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == MEASURE);

endmodule

// File: tb/tb_out_pulse_monitor.sv
// Drives two monitor configurations with the same stimulus and checks both every cycle
// against a run-length model of the pulse/queue rules.
module tb_out_pulse_monitor;

  logic clk;
  logic reset;
  logic sig_in;
  logic rec_ready;

  logic       a_valid, a_sat, a_ovf, a_busy;
  logic [7:0] a_width;
  logic [15:0] a_evt;
  logic       b_valid, b_sat, b_ovf, b_busy;
  logic [3:0] b_width;
  logic [15:0] b_evt;

  out_pulse_monitor #(.WIDTH_W(8), .MIN_WIDTH(1), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .sig_in(sig_in),
    .rec_valid(a_valid), .rec_ready(rec_ready), .rec_width(a_width), .rec_sat(a_sat),
    .evt_count(a_evt), .overflow(a_ovf), .busy(a_busy)
  );

  out_pulse_monitor #(.WIDTH_W(4), .MIN_WIDTH(2), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .sig_in(sig_in),
    .rec_valid(b_valid), .rec_ready(rec_ready), .rec_width(b_width), .rec_sat(b_sat),
    .evt_count(b_evt), .overflow(b_ovf), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int w;
    bit s;
  } rec_m;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   wmax [2] = '{255, 15};
  int   minw [2] = '{1, 2};
  int   depth = 4;
  bit   prev [2];
  bit   inp  [2];
  int   run  [2];
  int   evt  [2];
  bit   ovf  [2];
  rec_m mq   [2][16];
  int   mhead[2];
  int   mcnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a pulse is a run of high samples that starts after a low sample; its length is
  // clipped to the counter maximum, and it is queued when at least minw samples long.
  task automatic model_edge(input int k, input bit s, input bit rdy, input bit rst);
    bit pop;
    bit qual;
    int len;
    if (rst) begin
      prev[k] = 1'b1; inp[k] = 1'b0; run[k] = 0; evt[k] = 0; ovf[k] = 1'b0;
      mhead[k] = 0; mcnt[k] = 0;
      return;
    end
    pop  = (mcnt[k] > 0) && rdy;
    qual = 1'b0;
    len  = run[k];
    if (inp[k]) begin
      if (s) run[k]++;
      else begin
        inp[k] = 1'b0;
        len    = run[k];
        qual   = (len >= minw[k]);
      end
    end else if (s && !prev[k]) begin
      inp[k] = 1'b1;
      run[k] = 1;
    end
    prev[k] = s;
    if (pop) begin
      mhead[k] = (mhead[k] + 1) % 16;
      mcnt[k]--;
    end
    if (qual) begin
      evt[k] = (evt[k] + 1) % 65536;
      if (mcnt[k] >= depth) ovf[k] = 1'b1;
      else begin
        mq[k][(mhead[k] + mcnt[k]) % 16].w = (len > wmax[k]) ? wmax[k] : len;
        mq[k][(mhead[k] + mcnt[k]) % 16].s = (len > wmax[k]);
        mcnt[k]++;
      end
    end
  endtask

  task automatic compare_dut(input int k, input logic v, input logic [7:0] w, input logic s,
                             input logic [15:0] ev, input logic ov, input logic bz);
    string p;
    p = (k == 0) ? "a" : "b";
    check({p, "_valid"}, 32'(v), 32'(mcnt[k] > 0));
    if (mcnt[k] > 0) begin
      check({p, "_width"}, 32'(w), 32'(mq[k][mhead[k]].w));
      check({p, "_sat"}, 32'(s), 32'(mq[k][mhead[k]].s));
    end
    check({p, "_evt_count"}, 32'(ev), 32'(evt[k]));
    check({p, "_overflow"}, 32'(ov), 32'(ovf[k]));
    check({p, "_busy"}, 32'(bz), 32'(inp[k]));
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input logic s, input logic rdy, input logic rst);
    sig_in    = s;
    rec_ready = rdy;
    reset     = rst;
    @(posedge clk);
    model_edge(0, s, rdy, rst);
    model_edge(1, s, rdy, rst);
    @(negedge clk);
    compare_dut(0, a_valid, a_width, a_sat, a_evt, a_ovf, a_busy);
    compare_dut(1, b_valid, {4'b0, b_width}, b_sat, b_evt, b_ovf, b_busy);
  endtask

  task automatic pulse(input int hi, input int lo, input logic rdy);
    for (int i = 0; i < hi; i++) step(1'b1, rdy, 1'b0);
    for (int i = 0; i < lo; i++) step(1'b0, rdy, 1'b0);
  endtask

  initial begin
    sig_in    = 1'b1;
    rec_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);

    // Reset / startup with the level already high
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_width", 32'(a_width), 32'd0);
    check("rst_sat", 32'(a_sat), 32'd0);
    check("rst_evt", 32'(a_evt), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_b_width", 32'(b_width), 32'd0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("startup_evt", 32'(a_evt), 32'd0);
    check("startup_valid", 32'(a_valid), 32'd0);

    // Single 3-cycle pulse
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("single_valid", 32'(a_valid), 32'd1);
    check("single_width", 32'(a_width), 32'd3);
    check("single_b_width", 32'(b_width), 32'd3);
    step(1'b0, 1'b1, 1'b0);
    check("single_drained", 32'(a_valid), 32'd0);
    check("single_evt", 32'(a_evt), 32'd1);

    // Glitch filtering and back-to-back pulses
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    pulse(1, 2, 1'b1);
    check("glitch_b_evt", 32'(b_evt), 32'd0);
    check("glitch_a_evt", 32'(a_evt), 32'd1);
    pulse(2, 1, 1'b1);
    pulse(4, 3, 1'b1);
    check("b2b_b_evt", 32'(b_evt), 32'd2);
    check("b2b_a_evt", 32'(a_evt), 32'd3);

    // Saturation
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    pulse(20, 1, 1'b1);
    check("sat_b_width", 32'(b_width), 32'd15);
    check("sat_b_sat", 32'(b_sat), 32'd1);
    check("sat_a_width", 32'(a_width), 32'd20);
    check("sat_a_sat", 32'(a_sat), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    pulse(5, 1, 1'b1);
    check("post_sat_b_width", 32'(b_width), 32'd5);
    check("post_sat_b_sat", 32'(b_sat), 32'd0);
    step(1'b0, 1'b1, 1'b0);

    // Overflow with the consumer stalled, then push+pop on a full FIFO
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int w = 1; w <= 5; w++) pulse(w, 2, 1'b0);
    check("ovf_a_evt", 32'(a_evt), 32'd5);
    check("ovf_a_flag", 32'(a_ovf), 32'd1);
    check("ovf_a_head", 32'(a_width), 32'd1);
    check("ovf_b_evt", 32'(b_evt), 32'd4);
    check("ovf_b_flag", 32'(b_ovf), 32'd0);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);
    check("drain_a_ovf", 32'(a_ovf), 32'd1);
    check("drain_a_evt", 32'(a_evt), 32'd6);
    check("drain_a_valid", 32'(a_valid), 32'd0);

    // Reset with records queued and a pulse in progress
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    pulse(3, 1, 1'b0);
    pulse(4, 1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("midrst_valid", 32'(a_valid), 32'd0);
    check("midrst_evt", 32'(a_evt), 32'd0);
    check("midrst_ovf", 32'(a_ovf), 32'd0);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    check("midrst_busy", 32'(a_busy), 32'd0);
    check("midrst_no_rec", 32'(a_evt), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    pulse(2, 1, 1'b1);
    check("midrst_after_evt", 32'(a_evt), 32'd1);

    // Randomized pulse trains with random back-pressure and occasional reset
    for (int i = 0; i < 250; i++) begin
      int hi;
      int lo;
      hi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(1, 6));
      lo = int'($urandom_range(1, 3));
      for (int j = 0; j < hi; j++) step(1'b1, ($urandom_range(0, 3) != 0), 1'b0);
      for (int j = 0; j < lo; j++) step(1'b0, ($urandom_range(0, 3) != 0), 1'b0);
      if ($urandom_range(0, 39) == 0) step(($urandom_range(0, 1) != 0), 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
